// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. Holds the program counter,
// selects the next PC (sequential, branch, jump, register jump), rejects
// next-PC values outside the instruction memory window and parks the block
// in HALT until reset when such a value is seen.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  npc_sel,
   input  logic        branch_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   input  logic [31:0] instruction,
   output logic [31:0] im_addr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        halted,
   output logic        addr_fault
);

   // Inclusive byte-address window of the instruction memory.
   localparam logic [31:0] PC_LO = RESET_PC;
   localparam logic [31:0] PC_HI = RESET_PC + (32'(IM_WORDS) << 2) - 32'd4;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic        fault_q, fault_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;

   logic [31:0] br_offset;
   logic [31:0] next_pc;
   logic        next_legal;

   // Next-PC candidate from the selected source; pc4_q is always pc_q + 4.
   always_comb begin
      br_offset = {{14{imm16[15]}}, imm16, 2'b00};
      next_pc   = pc4_q;
      case (npc_sel)
         2'b00: next_pc = pc4_q;
         2'b01: begin
            if (branch_taken) begin
               next_pc = pc4_q + br_offset;
            end else begin
               next_pc = pc4_q;
            end
         end
         2'b10:   next_pc = {pc4_q[31:28], instr_index, 2'b00};
         2'b11:   next_pc = jr_target;
         default: next_pc = pc4_q;
      endcase
   end

   // A next PC is legal only if word aligned and inside the memory window;
   // a sequential step off the top word lands above PC_HI and is rejected.
   always_comb begin
      next_legal = (next_pc[1:0] == 2'b00) && (next_pc >= PC_LO) && (next_pc <= PC_HI);
   end

   // RUN/HALT transition and PC update; stall freezes everything in RUN.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (stall) begin
               state_d = ST_RUN;
            end else if (next_legal) begin
               pc_d = next_pc;
            end else begin
               state_d = ST_HALT;
               fault_d = 1'b1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
      pc4_d    = pc_d + 32'd4;
      valid_d  = (state_d == ST_RUN);
      halted_d = (state_d == ST_HALT);
   end

   // State and registered outputs; reset forces RUN at RESET_PC immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         pc4_q    <= RESET_PC + 32'd4;
         fault_q  <= 1'b0;
         valid_q  <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc4_q    <= pc4_d;
         fault_q  <= fault_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   // Fetched word is forced to zero while not fetching.
   always_comb begin
      if (valid_q) begin
         if_instr = instruction;
      end else begin
         if_instr = 32'h0000_0000;
      end
   end

   assign im_addr    = pc_q;
   assign if_pc      = pc_q;
   assign if_pc4     = pc4_q;
   assign if_valid   = valid_q;
   assign halted     = halted_q;
   assign addr_fault = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic,
// compared against a behavioural model of PC/HALT/fault behaviour.
module tb_fetch_ctrl;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int          WORDS = 1024;
   localparam logic [31:0] TOP   = BASE + 32'(WORDS * 4) - 32'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  npc_sel;
   logic        branch_taken;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic [31:0] instruction;
   logic [31:0] im_addr, if_instr, if_pc, if_pc4;
   logic        if_valid, halted, addr_fault;

   logic [31:0] mem [0:WORDS-1];
   logic [31:0] mem_off;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_halt;
   logic        m_fault;

   int err_cnt = 0;
   int chk_cnt = 0;

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
      .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
      .jr_target(jr_target), .instruction(instruction), .im_addr(im_addr),
      .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
      .halted(halted), .addr_fault(addr_fault)
   );

   always #5 clk = ~clk;

   // Combinational instruction memory
   always_comb begin
      mem_off = im_addr - BASE;
      if (mem_off < 32'(WORDS * 4)) instruction = mem[mem_off[11:2]];
      else instruction = 32'hDEAD_BEEF;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [1:0] sel, input logic bt,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] jr);
      logic [31:0] seq;
      int          off;
      seq = m_pc + 32'd4;
      off = 4 * int'($signed(imm));
      case (sel)
         2'd0:    return seq;
         2'd1:    return bt ? seq + 32'(off) : seq;
         2'd2:    return (seq & 32'hF000_0000) + (32'(idx) * 32'd4);
         default: return jr;
      endcase
   endfunction

   function automatic logic is_legal(input logic [31:0] a);
      return (a % 32'd4 == 32'd0) && (a >= BASE) && (a <= TOP);
   endfunction

   task automatic check_all(input string tag);
      logic [31:0] exp_instr;
      exp_instr = m_halt ? 32'h0 : mem[(m_pc - BASE) / 32'd4];
      check_eq({tag, ".im_addr"}, im_addr, m_pc);
      check_eq({tag, ".if_pc"}, if_pc, m_pc);
      check_eq({tag, ".if_pc4"}, if_pc4, m_pc + 32'd4);
      check_eq({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, !m_halt});
      check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
      check_eq({tag, ".addr_fault"}, {31'd0, addr_fault}, {31'd0, m_fault});
      check_eq({tag, ".if_instr"}, if_instr, exp_instr);
   endtask

   // One clock edge with the given inputs; model advances alongside.
   task automatic step(input string tag, input logic st, input logic [1:0] sel, input logic bt,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
      logic [31:0] np;
      stall = st; npc_sel = sel; branch_taken = bt;
      imm16 = imm; instr_index = idx; jr_target = jr;
      np = model_next(sel, bt, imm, idx, jr);
      @(posedge clk);
      m_fault = 1'b0;
      if (!m_halt && !st) begin
         if (is_legal(np)) m_pc = np;
         else begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
         end
      end
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      #1 reset = 1'b1;
      #1;
      m_pc = BASE; m_halt = 1'b0; m_fault = 1'b0;
      check_all({tag, ".async"});
      reset = 1'b0;
   endtask

   task automatic goto(input logic [31:0] a);
      step("goto", 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, a);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      reset = 1'b1; stall = 1'b0; npc_sel = 2'd0; branch_taken = 1'b0;
      imm16 = 16'h0; instr_index = 26'h0; jr_target = 32'h0;
      m_pc = BASE; m_halt = 1'b0; m_fault = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_state");
      check_eq("reset_pc4", if_pc4, 32'h0000_3004);
      reset = 1'b0;

      // Sequential fetch
      for (int k = 1; k <= 3; k++) step("seq", 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      check_eq("seq_pc3", if_pc, 32'h0000_300C);
      check_eq("seq_instr3", if_instr, mem[3]);

      // Branch taken backwards and not taken
      goto(32'h0000_3008);
      step("br_t", 1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0);
      check_eq("br_taken_pc", if_pc, 32'h0000_3004);
      goto(32'h0000_3008);
      step("br_nt", 1'b0, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
      check_eq("br_not_taken_pc", if_pc, 32'h0000_300C);

      // Jump, stalled then released
      goto(32'h0000_3010);
      step("jmp_stall", 1'b1, 2'd2, 1'b0, 16'h0, 26'h0000C05, 32'h0);
      check_eq("jmp_stall_pc", if_pc, 32'h0000_3010);
      step("jmp", 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C05, 32'h0);
      check_eq("jmp_pc", if_pc, 32'h0000_3014);

      // Illegal target under stall is ignored
      step("ill_stall", 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
      check_eq("ill_stall_fault", {31'd0, addr_fault}, 32'd0);

      // Misaligned register jump faults and halts
      step("jr_mis", 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
      check_eq("jr_mis_fault", {31'd0, addr_fault}, 32'd1);
      check_eq("jr_mis_pc", if_pc, 32'h0000_3014);
      step("halt1", 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      step("halt2", 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3100);
      check_eq("halt_instr", if_instr, 32'h0);
      pulse_reset("rst_halt");
      check_eq("rst_halt_pc", if_pc, 32'h0000_3000);

      // Top boundary
      goto(32'h0000_3FFC);
      check_eq("top_pc", if_pc, 32'h0000_3FFC);
      step("top_seq", 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      check_eq("top_halt", {31'd0, halted}, 32'd1);
      pulse_reset("rst_top");
      goto(32'h0000_2FFC);
      check_eq("below_fault", {31'd0, addr_fault}, 32'd1);
      pulse_reset("rst_below");

      // Reset during stall, then first edge uses that edge's inputs
      goto(32'h0000_3040);
      step("stall_hold", 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      stall = 1'b1;
      pulse_reset("rst_stall");
      step("post_rst", 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3200);
      check_eq("post_rst_pc", if_pc, 32'h0000_3200);

      // Randomized traffic, mostly legal targets
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] r, jr;
         logic [25:0] idx;
         logic [15:0] imm;
         r   = $urandom;
         jr  = (r[3:0] == 4'd0) ? $urandom : BASE + 32'($urandom_range(0, WORDS - 1) * 4);
         if (r[7:4] == 4'd1) jr = jr + 32'(r[9:8]);
         idx = 26'((BASE >> 2) + 32'($urandom_range(0, WORDS + 8)));
         imm = 16'($signed($urandom_range(0, 80)) - 40);
         step("rnd", (r[12:10] == 3'd0), r[14:13], r[15], imm, idx, jr);
         if (m_halt && r[18:16] == 3'd0) pulse_reset("rnd_rst");
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, address of first instruction fetched after reset.
REQ-002 Parameter IM_WORDS, 1024, number of 32-bit words in the instruction memory.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold the current PC; no PC update this cycle.
REQ-006 npc_sel  input  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 register jump.
REQ-007 branch_taken  input  1  branch condition result; meaningful only when npc_sel=01.
REQ-008 imm16  input  16  branch offset, in words.
REQ-009 instr_index  input  26  jump target field.
REQ-010 jr_target  input  32  register jump target.
REQ-011 instruction  input  32  word returned combinationally by the instruction memory for im_addr.
REQ-012 im_addr  output  32  byte address driven to the instruction memory; equals pc.
REQ-013 if_instr  output  32  current instruction; 32'h0000_0000 when if_valid=0.
REQ-014 if_pc  output  32  address of if_instr.
REQ-015 if_pc4  output  32  if_pc + 4.
REQ-016 if_valid  output  1  if_instr is a legal fetch.
REQ-017 halted  output  1  block is in HALT.
REQ-018 addr_fault  output  1  one-cycle pulse when an illegal next PC is rejected.

Function
REQ-019 The block SHALL hold a 32-bit pc register and a two-state FSM, RUN and HALT.
REQ-020 In RUN with stall=0, pc SHALL load next_pc on each rising edge; with stall=1, pc and FSM SHALL hold.
REQ-021 Sequential: next_pc SHALL be pc+4 (32-bit wrapping arithmetic).
REQ-022 Branch: taken -> next_pc SHALL be pc+4+(sign_extend(imm16)<<2); not taken -> pc+4.
REQ-023 Jump: next_pc SHALL be {pc4[31:28], instr_index, 2'b00}, where pc4 = pc+4.
REQ-024 Register jump: next_pc SHALL be jr_target unchanged.
REQ-025 next_pc SHALL be legal iff next_pc[1:0]=00 and RESET_PC <= next_pc <= RESET_PC+4*IM_WORDS-4 (unsigned).
REQ-026 Illegal next_pc in RUN with stall=0: pc SHALL hold, FSM SHALL go to HALT, addr_fault SHALL pulse high for exactly that cycle.
REQ-027 An illegal next_pc while stall=1 SHALL NOT fault and SHALL NOT change state.
REQ-028 pc+4 crossing the top word SHALL be treated as illegal (fault), not wrapped.
REQ-029 HALT SHALL be absorbing until reset: pc held, if_valid=0, halted=1, stall and npc_sel ignored.
REQ-030 if_valid SHALL be 1 in RUN, 0 in HALT; if_instr SHALL equal instruction when if_valid=1.
REQ-031 Outputs im_addr, if_pc, if_pc4 SHALL be functions of pc only; latency from select inputs to new pc is one clock edge.

Reset
REQ-032 Asserting reset SHALL immediately, without a clock edge, force pc=RESET_PC, FSM=RUN, addr_fault=0.
REQ-033 After reset: im_addr=if_pc=32'h0000_3000, if_pc4=32'h0000_3004, if_valid=1, halted=0.
REQ-034 Reset asserted mid-stall or in HALT SHALL take effect identically; the first update after release SHALL use the inputs of that edge.

Verification
REQ-035 Reset release, npc_sel=00, stall=0, 3 edges -> pc 0x3000, 0x3004, 0x3008, 0x300C; if_instr tracks memory words 0..3.
REQ-036 pc=0x3008, npc_sel=01, branch_taken=1, imm16=16'hFFFE -> next pc 0x3004; with branch_taken=0 -> 0x300C.
REQ-037 pc=0x3010, npc_sel=10, instr_index=26'h0000C05 -> next pc 0x0000_3014; stall=1 on the same cycle -> pc stays 0x3010.
REQ-038 npc_sel=11, jr_target=0x0000_3002 -> pc held, addr_fault=1 for one cycle, halted=1, if_valid=0, if_instr=0; further edges leave pc unchanged.
REQ-039 pc=0x3FFC, npc_sel=00 -> fault and HALT; jr_target=0x2FFC -> fault; jr_target=0x3FFC -> legal, pc=0x3FFC.
REQ-040 Reset pulsed asynchronously between edges while HALT -> pc=0x3000, halted=0, if_valid=1 before the next edge.
